radix4_div: RTL and testbench
=============================

// Module: radix4_div
// PURPOSE
//   Iterative unsigned radix-4 restoring divider: the inverse companion to radix4_mult.
//   Computes Q = A / B and R = A % B, retiring 2 quotient bits per cycle.
//   Uses the same valid_in/valid_out operand and result interface style as radix4_mult,
//   plus a ready output because the unit is not pipelined (one operation in flight).
// PARAMETERS
//   WIDTH  32  operand/result width; must be even (elaboration $error otherwise)
// PORTS
//   CLK        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   valid_in   in   1      operands A/B valid this cycle
//   ready      out  1      divider idle; valid_in is accepted only when ready=1
//   A          in   WIDTH  dividend
//   B          in   WIDTH  divisor
//   Q          out  WIDTH  quotient (registered)
//   R          out  WIDTH  remainder (registered)
//   div_by_zero out 1      qualifies Q/R: last result had B==0
//   valid_out  out  1      one-cycle pulse: Q/R/div_by_zero are new
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; Q, R, div_by_zero, valid_out=0; ready=1 once rst deasserts.
//   FSM states: IDLE, CALC, DONE. ready = (state==IDLE).
//   IDLE:
//     - valid_in=1 at edge E accepts the operation: latch A and B; precompute 3B (WIDTH+2 bits).
//     - Clear the partial remainder P (WIDTH+2 bits); load the dividend shift reg with A.
//     - Load cnt=WIDTH/2. Next state: CALC, or DONE if B==0.
//     - valid_in=0 holds IDLE.
//   CALC, one iteration per edge:
//     - P' = {P, top 2 dividend bits}; shift the dividend left by 2.
//     - Digit d = largest k in {3,2,1,0} with k*B <= P'; P = P' - d*B.
//     - Shift d into the quotient LSBs; cnt = cnt-1.
//     - On the edge where cnt goes 1->0: load Q and R (P[WIDTH-1:0]), set div_by_zero=0, state DONE.
//   DONE: valid_out=1 for exactly that one cycle; next edge -> IDLE (ready=1).
//   Latency and throughput:
//     - Normal op: valid_out is high in the cycle following edge E+WIDTH/2 (16 cycles for WIDTH=32).
//     - Divide by zero: valid_out is high in the cycle after E+1 with Q='1, R=A, div_by_zero=1.
//     - Max throughput: one op per WIDTH/2+2 cycles; valid_in held high is re-accepted in the IDLE cycle.
//   Interface rules:
//     - Q/R/div_by_zero hold their values between valid_out pulses.
//     - They change only on a completing edge.
//     - valid_in while ready=0 is ignored; no queuing.
//     - A/B may change freely after the accepting edge.
//   Arithmetic: the remainder never exceeds WIDTH+2 bits; final R < B always holds.
//   Reset mid-operation: abort immediately with no valid_out pulse.
//     - Outputs clear to 0; the first operation after reset behaves as from power-up.
// TESTING
//   1. A=10000, B=100 -> Q=100, R=0, div_by_zero=0.
//      valid_out arrives exactly 16 cycles after acceptance; ready=0 throughout CALC.
//   2. A=32'hFFFF_FFFF, B=1 -> Q=32'hFFFF_FFFF, R=0. Also A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> Q=1, R=0.
//   3. A=5, B=7 -> Q=0, R=5. Also A=0, B=9 -> Q=0, R=0.
//   4. A=7, B=0 -> div_by_zero=1, Q=32'hFFFF_FFFF, R=7.
//      valid_out arrives 1 cycle after acceptance; the next op (A=9, B=3) gives Q=3, div_by_zero=0.
//   5. Assert rst 5 cycles into a 1000/3 op:
//      - Q=R=0, no valid_out.
//      - After release, 1000/3 -> Q=333, R=1 with the normal latency.
//   6. valid_in held high for 1000 random A/B pairs, including B=0 and B>A:
//      - Each result matches A/B and A%B.
//      - Exactly one valid_out per accepted op; Q/R are stable between pulses.

Source files
------------

// File: rtl/radix4_div.sv
// Iterative unsigned radix-4 restoring divider: Q = A / B, R = A % B.
// Retires two quotient bits per cycle; one operation in flight, gated by ready.
module radix4_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             valid_out
);

  if (WIDTH % 2 != 0) begin : g_width_check
    $error("radix4_div: WIDTH must be even");
  end

  localparam int unsigned CW = $clog2(WIDTH / 2 + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH+1:0] b3;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             zero_op;

  logic [WIDTH+1:0] p_shift;
  logic [WIDTH+1:0] b1;
  logic [WIDTH+1:0] b2;
  logic [WIDTH-1:0] p_next;
  logic [1:0]       digit;
  logic [WIDTH-1:0] quo_next;

  assign ready = (state == IDLE);

  // The stored remainder stays below B, so it fits WIDTH bits; only the
  // shifted-in partial remainder P' needs the two extra bits.
  always_comb begin
    p_shift = {p, dvd[WIDTH-1:WIDTH-2]};
    b1      = {2'b00, b_reg};
    b2      = {1'b0, b_reg, 1'b0};
    digit   = 2'd0;
    p_next  = p_shift[WIDTH-1:0];
    if (p_shift >= b3) begin
      digit  = 2'd3;
      p_next = WIDTH'(p_shift - b3);
    end else if (p_shift >= b2) begin
      digit  = 2'd2;
      p_next = WIDTH'(p_shift - b2);
    end else if (p_shift >= b1) begin
      digit  = 2'd1;
      p_next = WIDTH'(p_shift - b1);
    end
    quo_next = {quo[WIDTH-3:0], digit};
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      b_reg       <= '0;
      b3          <= '0;
      p           <= '0;
      dvd         <= '0;
      quo         <= '0;
      cnt         <= '0;
      zero_op     <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      valid_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          if (valid_in) begin
            b_reg   <= B;
            b3      <= {2'b00, B} + {1'b0, B, 1'b0};
            p       <= '0;
            dvd     <= A;
            quo     <= '0;
            cnt     <= CW'(WIDTH / 2);
            zero_op <= (B == '0);
            state   <= (B == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          p   <= p_next;
          dvd <= dvd << 2;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Q           <= quo_next;
            R           <= p_next;
            div_by_zero <= 1'b0;
            valid_out   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // A divide-by-zero publishes its result here, one edge after acceptance;
          // a normal op already pulsed on its final CALC edge.
          if (zero_op) begin
            Q           <= '1;
            R           <= dvd;
            div_by_zero <= 1'b1;
            valid_out   <= 1'b1;
          end else begin
            valid_out   <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_div.sv
// Self-checking bench for radix4_div: directed cases with literal expectations
// plus a cycle-level behavioural model compared against the DUT every cycle.
module tb_radix4_div;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic         ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         div_by_zero;
  logic         valid_out;

  always #5 CLK = ~CLK;

  radix4_div #(.WIDTH(W)) dut (
    .CLK(CLK), .rst(rst), .valid_in(valid_in), .ready(ready),
    .A(A), .B(B), .Q(Q), .R(R),
    .div_by_zero(div_by_zero), .valid_out(valid_out)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per edge, decide acceptance from the model's own
  // availability and schedule the result by plain / and %.
  int           n = 0;
  int           busy_until = 0;
  int           due = -1;
  int           accepts = 0;
  bit           m_rdy;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_z = 1'b0, p_z = 1'b0, m_vo = 1'b0;

  always @(posedge CLK) begin
    n++;
    if (rst) begin
      m_q = '0; m_r = '0; m_z = 1'b0; m_vo = 1'b0;
      due = -1;
      busy_until = n;
    end else begin
      m_rdy = (n - 1 >= busy_until);
      m_vo  = (due == n);
      if (m_vo) begin
        m_q = p_q; m_r = p_r; m_z = p_z;
      end
      if (valid_in && m_rdy) begin
        accepts++;
        if (B == '0) begin
          p_q = '1; p_r = A; p_z = 1'b1;
          due = n + 1;
          busy_until = n + 1;
        end else begin
          p_q = A / B; p_r = A % B; p_z = 1'b0;
          due = n + W / 2;
          busy_until = n + W / 2 + 1;
        end
      end
    end
  end

  int vo_cnt = 0;

  always @(negedge CLK) begin
    if (!rst) begin
      check("valid_out", valid_out, m_vo);
      check("ready", ready, (n >= busy_until));
      check("q_hold", Q, m_q);
      check("r_hold", R, m_r);
      check("dbz_hold", div_by_zero, m_z);
      if (valid_out) vo_cnt++;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input int elat);
    int to;
    int lat;
    to = 0;
    while (!ready && to < 100) begin
      tick();
      to++;
    end
    check({name, "_ready_before"}, ready, 1'b1);
    valid_in = 1'b1; A = a; B = b;
    tick();
    valid_in = 1'b0; A = $urandom; B = $urandom;
    lat = 0;
    while (!valid_out && lat < 40) begin
      check({name, "_busy"}, ready, 1'b0);
      tick();
      lat++;
    end
    check({name, "_pulse"}, valid_out, 1'b1);
    check({name, "_latency"}, lat, elat);
    check({name, "_q"}, Q, eq);
    check({name, "_r"}, R, er);
    check({name, "_dbz"}, div_by_zero, ez);
  endtask

  initial begin
    int start_acc;
    int start_vo;
    int cyc;
    int sel;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_q", Q, '0);
    check("reset_r", R, '0);
    check("reset_dbz", div_by_zero, 1'b0);
    check("reset_vo", valid_out, 1'b0);
    check("reset_ready", ready, 1'b1);

    do_op("t1", 32'd10000, 32'd100, 32'd100, 32'd0, 1'b0, 16);
    check("model_pin_q", m_q, 32'd100);
    do_op("t2a", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 16);
    do_op("t2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 16);
    do_op("t3a", 32'd5, 32'd7, 32'd0, 32'd5, 1'b0, 16);
    do_op("t3b", 32'd0, 32'd9, 32'd0, 32'd0, 1'b0, 16);
    do_op("t4a", 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1);
    check("model_pin_r", m_r, 32'd7);
    do_op("t4b", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 16);

    // Reset in the middle of a 1000/3 operation.
    while (!ready) tick();
    valid_in = 1'b1; A = 32'd1000; B = 32'd3;
    tick();
    valid_in = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrst_q", Q, '0);
    check("midrst_r", R, '0);
    check("midrst_vo", valid_out, 1'b0);
    check("midrst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    start_vo = vo_cnt;
    repeat (20) tick();
    check("midrst_no_pulse", vo_cnt - start_vo, 0);
    do_op("t5", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 16);

    // Back-to-back random traffic with valid_in held high.
    start_acc = accepts;
    start_vo  = vo_cnt;
    cyc = 0;
    valid_in = 1'b1;
    while (accepts - start_acc < 1000 && cyc < 40000) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: begin A = $urandom; B = '0; end
        1: begin A = $urandom_range(0, 1000); B = A + 1 + $urandom_range(0, 1000); end
        2: begin A = $urandom; B = $urandom_range(1, 15); end
        3: begin A = $urandom; B = $urandom >> $urandom_range(0, 31); end
        default: begin A = $urandom; B = $urandom; end
      endcase
      tick();
      cyc++;
    end
    valid_in = 1'b0;
    repeat (20) tick();
    check("rand_accepts", accepts - start_acc, 1000);
    check("rand_pulses", vo_cnt - start_vo, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
